// File: rtl/btn_debounce.sv
// btn_debounce: per-channel 2-flop synchroniser, debouncer, press/release strobes and long-press flag.
// Define BTN_DEBOUNCE_REPEAT_EN to add auto-repeat press strobes while a button stays held.

module btn_debounce_ch #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES     = 50_000_000
`ifdef BTN_DEBOUNCE_REPEAT_EN
  , parameter int REPEAT_CYCLES = 10_000_000
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rel,
  output logic hold
);
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] H_MAX  = HW'(HOLD_CYCLES);

  logic          sync0, sync1;
  logic [DW-1:0] dcnt;
  logic [HW-1:0] hcnt;
  logic          accept, rep_fire;

  assign accept = (sync1 != level) && (dcnt == D_LAST);
  assign hold   = level && (hcnt == H_MAX);

`ifdef BTN_DEBOUNCE_REPEAT_EN
  localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RW-1:0] R_LAST = RW'(REPEAT_CYCLES - 1);
  localparam logic [HW-1:0] H_LAST = HW'(HOLD_CYCLES - 1);
  logic [RW-1:0] rcnt;

  // accept while level=1 is a release, which cancels any repeat due in the same cycle
  assign rep_fire = level && !accept && ((hcnt == H_LAST) || (hold && (rcnt == R_LAST)));

  always_ff @(posedge clk) begin
    if (rst || !hold)        rcnt <= '0;
    else if (rcnt == R_LAST) rcnt <= '0;
    else                     rcnt <= rcnt + RW'(1);
  end
`else
  assign rep_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
      level <= 1'b0;
      dcnt  <= '0;
      hcnt  <= '0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      sync0 <= raw;
      sync1 <= sync0;
      press <= (accept && sync1) || rep_fire;
      rel   <= accept && !sync1;
      if (sync1 == level) dcnt <= '0;
      else if (accept) begin
        level <= sync1;
        dcnt  <= '0;
      end else dcnt <= dcnt + DW'(1);
      if (accept || !level)  hcnt <= '0;
      else if (hcnt != H_MAX) hcnt <= hcnt + HW'(1);
    end
  end
endmodule

module btn_debounce #(
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES     = 50_000_000,
  parameter int REPEAT_CYCLES   = 10_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_hold
);
  if (DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_cfg
    $error("btn_debounce: cycle parameters must be >= 1");
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES)
`ifdef BTN_DEBOUNCE_REPEAT_EN
      , .REPEAT_CYCLES(REPEAT_CYCLES)
`endif
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .raw  (btn_raw[i]),
      .level(btn_level[i]),
      .press(btn_press[i]),
      .rel  (btn_release[i]),
      .hold (btn_hold[i])
    );
  end
endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: directed vector table, hand-written hold/reset sequences, random
// stimulus, all checked against a sample-history reference model.
module tb_btn_debounce;
  localparam int NB = 5, DB = 4, HC = 20, RC = 5;

  logic          clk = 1'b0, rst = 1'b1;
  logic [NB-1:0] btn_raw = '0;
  logic [NB-1:0] btn_level, btn_press, btn_release, btn_hold;
  int checks = 0, errors = 0;

  btn_debounce #(.N_BTN(NB), .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HC), .REPEAT_CYCLES(RC)) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .btn_level(btn_level),
    .btn_press(btn_press), .btn_release(btn_release), .btn_hold(btn_hold));

  always #5 clk = ~clk;

  // Model: a level is accepted when the last DB synchronised samples all disagree with it;
  // age counts cycles since the accepted press.
  bit m_s0[NB], m_s1[NB], m_lvl[NB];
  bit hist[NB][$];
  int m_age[NB];
  logic [NB-1:0] e_lvl = '0, e_prs = '0, e_rel = '0, e_hld = '0;

  task automatic model_step(input bit r, input logic [NB-1:0] raw);
    for (int b = 0; b < NB; b++) begin
      bit old_s1, acc;
      old_s1 = m_s1[b];
      e_prs[b] = 1'b0;
      e_rel[b] = 1'b0;
      if (r) begin
        m_s0[b] = 0; m_s1[b] = 0; m_lvl[b] = 0; m_age[b] = 0;
        hist[b].delete();
      end else begin
        m_s1[b] = m_s0[b];
        m_s0[b] = raw[b];
        hist[b].push_back(old_s1);
        if (hist[b].size() > DB) void'(hist[b].pop_front());
        acc = (hist[b].size() == DB);
        for (int k = 0; k < hist[b].size(); k++) if (hist[b][k] == m_lvl[b]) acc = 0;
        if (acc) begin
          m_lvl[b] = old_s1;
          m_age[b] = 0;
          hist[b].delete();
          e_prs[b] = old_s1;
          e_rel[b] = !old_s1;
        end else if (m_lvl[b]) begin
          m_age[b]++;
`ifdef BTN_DEBOUNCE_REPEAT_EN
          if (m_age[b] == HC || (m_age[b] > HC && (m_age[b] - HC) % RC == 0)) e_prs[b] = 1'b1;
`endif
        end
      end
      e_lvl[b] = m_lvl[b];
      e_hld[b] = m_lvl[b] && (m_age[b] >= HC);
    end
  endtask

  task automatic chk(input string nm, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic tick(input bit r, input logic [NB-1:0] raw);
    rst = r;
    btn_raw = raw;
    @(posedge clk);
    model_step(r, raw);
    #1;
    chk("model_level", btn_level, e_lvl);
    chk("model_press", btn_press, e_prs);
    chk("model_release", btn_release, e_rel);
    chk("model_hold", btn_hold, e_hld);
  endtask

  typedef struct {
    bit r; logic [NB-1:0] raw; int n;
    logic [NB-1:0] lvl, prs, rel, hld;
  } vec_t;
  vec_t tbl[$];

  initial begin
    int n, first_hold;
    bit prev_h;
    int pk[$], exp_pk[$];
    logic [NB-1:0] cur;

    // rst, raw, cycles, then expected outputs after the last cycle
    tbl.push_back('{1, 5'b00000, 2, 5'b00000, 5'b00000, 5'b00000, 5'b00000});
    tbl.push_back('{0, 5'b00001, 5, 5'b00000, 5'b00000, 5'b00000, 5'b00000});
    tbl.push_back('{0, 5'b00001, 1, 5'b00001, 5'b00001, 5'b00000, 5'b00000});
    tbl.push_back('{0, 5'b00001, 1, 5'b00001, 5'b00000, 5'b00000, 5'b00000});
    tbl.push_back('{0, 5'b00000, 5, 5'b00001, 5'b00000, 5'b00000, 5'b00000});
    tbl.push_back('{0, 5'b00000, 1, 5'b00000, 5'b00000, 5'b00001, 5'b00000});
    tbl.push_back('{0, 5'b00000, 1, 5'b00000, 5'b00000, 5'b00000, 5'b00000});
    tbl.push_back('{0, 5'b00100, 1, 5'b00000, 5'b00000, 5'b00000, 5'b00000});
    tbl.push_back('{0, 5'b00000, 1, 5'b00000, 5'b00000, 5'b00000, 5'b00000});
    tbl.push_back('{0, 5'b00100, 2, 5'b00000, 5'b00000, 5'b00000, 5'b00000});
    tbl.push_back('{0, 5'b00000, 8, 5'b00000, 5'b00000, 5'b00000, 5'b00000});
    tbl.push_back('{0, 5'b01010, 5, 5'b00000, 5'b00000, 5'b00000, 5'b00000});
    tbl.push_back('{0, 5'b01010, 1, 5'b01010, 5'b01010, 5'b00000, 5'b00000});
    tbl.push_back('{0, 5'b01010, 1, 5'b01010, 5'b00000, 5'b00000, 5'b00000});
    tbl.push_back('{0, 5'b01000, 5, 5'b01010, 5'b00000, 5'b00000, 5'b00000});
    tbl.push_back('{0, 5'b01000, 1, 5'b01000, 5'b00000, 5'b00010, 5'b00000});
    tbl.push_back('{0, 5'b00000, 6, 5'b00000, 5'b00000, 5'b01000, 5'b00000});

    for (int i = 0; i < tbl.size(); i++) begin
      repeat (tbl[i].n) tick(tbl[i].r, tbl[i].raw);
      chk($sformatf("v%0d_level", i), btn_level, tbl[i].lvl);
      chk($sformatf("v%0d_press", i), btn_press, tbl[i].prs);
      chk($sformatf("v%0d_release", i), btn_release, tbl[i].rel);
      chk($sformatf("v%0d_hold", i), btn_hold, tbl[i].hld);
    end

    // long hold on bit 4
    repeat (3) tick(0, '0);
    n = 0;
    while (!btn_level[4] && n < 20) begin tick(0, 5'b10000); n++; end
    chk_int("hold_accept_latency", n, DB + 2);
    first_hold = -1;
    for (int k = 1; k <= 39; k++) begin
      tick(0, 5'b10000);
      if (btn_press[4]) pk.push_back(k);
      if (btn_hold[4] && first_hold < 0) first_hold = k;
    end
    chk_int("hold_rise", first_hold, HC);
`ifdef BTN_DEBOUNCE_REPEAT_EN
    exp_pk = '{20, 25, 30, 35};
`endif
    chk_int("repeat_count", pk.size(), exp_pk.size());
    for (int i = 0; i < pk.size() && i < exp_pk.size(); i++)
      chk_int($sformatf("repeat_at_%0d", i), pk[i], exp_pk[i]);
    n = 0;
    prev_h = btn_hold[4];
    while (btn_level[4] && n < 20) begin prev_h = btn_hold[4]; tick(0, '0); n++; end
    chk_int("release_latency", n, DB + 2);
    chk_int("hold_before_drop", int'(prev_h), 1);
    chk_int("hold_after_drop", int'(btn_hold[4]), 0);
    chk_int("release_strobe", int'(btn_release[4]), 1);
    tick(0, '0);
    chk_int("release_once", int'(btn_release[4]), 0);

    // reset while bit 0 is accepted and held
    n = 0;
    while (!btn_level[0] && n < 20) begin tick(0, 5'b00001); n++; end
    chk_int("pre_rst_accept", n, DB + 2);
    repeat (3) tick(0, 5'b00001);
    tick(1, 5'b00001);
    chk("rst_level", btn_level, '0);
    chk("rst_release", btn_release, '0);
    chk("rst_press", btn_press, '0);
    n = 0;
    do begin tick(0, 5'b00001); n++; end while (!btn_press[0] && n < 20);
    chk_int("press_after_rst", n, DB + 2);
    repeat (8) tick(0, '0);

    // reset mid-debounce discards the partial count
    repeat (4) tick(0, 5'b00001);
    chk("middeb_level", btn_level, '0);
    tick(1, 5'b00001);
    n = 0;
    do begin tick(0, 5'b00001); n++; end while (!btn_press[0] && n < 20);
    chk_int("middeb_latency", n, DB + 2);
    repeat (8) tick(0, '0);

    // random stimulus against the model
    cur = '0;
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < NB; b++) if ($urandom_range(0, 99) < 8) cur[b] = ~cur[b];
      tick($urandom_range(0, 499) == 0, cur);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
